spi_txn_sched: RTL and testbench

- Two-requester transaction scheduler in front of the 24-bit SPI master (`spi_controller`).
- Requester 0: host register path (LSI writes). Requester 1: autonomous poll engine.
- Arbitrates between them, issues one `tx_start` pulse per transfer, waits for `tx_end` with a timeout, returns RX word tagged with source, enforces a minimum idle gap between transfers (SS deassert time).

---
 rtl/spi_txn_sched.sv | 151 +++++++++++++++
 tb/tb_spi_txn_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sched.sv
// Two-requester scheduler for the 24-bit SPI master: one tx_start pulse per transfer, one registered response pulse per transfer (RX word or timeout), enforced idle gap between transfers.
// Accepted request -> tx_start next cycle. Requests are held off (ready low) outside IDLE; responses have no backpressure. Define SPI_SCHED_FIXED_PRIO_EN to give requester 0 fixed priority.
module spi_txn_sched #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13,
  parameter int GAP_CYCLES     = 4
) (
  input  logic        fxclk,
  input  logic        reset_in,
  input  logic        req0_valid,
  input  logic [23:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_data,
  output logic        req1_ready,
  output logic        spi_tx_start,
  output logic [23:0] spi_tx_data,
  input  logic        spi_tx_end,
  input  logic [23:0] spi_rx_data,
  output logic        rsp_valid,
  output logic        rsp_src,
  output logic [23:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_END,
    S_GAP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              src;
  logic              grant;
  logic              grant_vld;
  logic              accept;
  logic              end_hit;
  logic              to_hit;
`ifndef SPI_SCHED_FIXED_PRIO_EN
  logic              last_grant;
`endif

  // grant: 0 selects requester 0, 1 selects requester 1
  always_comb begin
    grant_vld = req0_valid | req1_valid;
`ifdef SPI_SCHED_FIXED_PRIO_EN
    grant     = ~req0_valid;
`else
    grant     = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
`endif
  end

  assign accept     = (state == S_IDLE) && grant_vld;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // A tx_end on the final counted cycle takes precedence over the timeout.
  assign end_hit = (state == S_WAIT_END) && spi_tx_end;
  assign to_hit  = (state == S_WAIT_END) && !spi_tx_end && (to_cnt == TO_LAST);

  always_ff @(posedge fxclk) begin
    if (reset_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    spi_tx_start = 1'b0;
    busy         = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        spi_tx_start = 1'b1;
        state_nxt    = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (end_hit || to_hit) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge fxclk) begin
    if (reset_in) begin
      spi_tx_data <= '0;
      src         <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      rsp_valid   <= 1'b0;
      rsp_src     <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
`ifndef SPI_SCHED_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      rsp_valid <= 1'b0;

      if (accept) begin
        spi_tx_data <= grant ? req1_data : req0_data;
        src         <= grant;
`ifndef SPI_SCHED_FIXED_PRIO_EN
        last_grant  <= grant;
`endif
      end

      if (state == S_LAUNCH) begin
        to_cnt <= '0;
      end else if (state == S_WAIT_END) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end

      if (end_hit) begin
        rsp_valid   <= 1'b1;
        rsp_src     <= src;
        rsp_data    <= spi_rx_data;
        rsp_timeout <= 1'b0;
      end else if (to_hit) begin
        rsp_valid   <= 1'b1;
        rsp_src     <= src;
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_txn_sched.sv
// Scoreboard bench for spi_txn_sched: directed requests push expected responses (with arrival cycle); a negedge monitor pops and compares.
module tb_spi_txn_sched;

  localparam int T = 4096;
  localparam int G = 4;

  logic        fxclk = 1'b0;
  logic        reset_in;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        spi_tx_start;
  logic [23:0] spi_tx_data;
  logic        spi_tx_end;
  logic [23:0] spi_rx_data;
  logic        rsp_valid, rsp_src, rsp_timeout, busy;
  logic [23:0] rsp_data;

  spi_txn_sched #(.TIMEOUT_CYCLES(T), .TO_W(13), .GAP_CYCLES(G)) dut (
    .fxclk(fxclk), .reset_in(reset_in),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .spi_tx_start(spi_tx_start), .spi_tx_data(spi_tx_data),
    .spi_tx_end(spi_tx_end), .spi_rx_data(spi_rx_data),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 fxclk = ~fxclk;

  typedef struct {
    logic        src;
    logic [23:0] data;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   both_cnt = 0;

  always @(posedge fxclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation, including its arrival cycle.
  always @(negedge fxclk) begin
    if (reset_in === 1'b0) begin
      if (req0_ready === 1'b1 && req1_ready === 1'b1) both_cnt++;
      if (rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_data), 32'hDEAD);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_src", 32'(rsp_src), 32'(e.src));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic push(input logic s, input logic [23:0] d, input logic to, input int c);
    exp_t e;
    e.src = s; e.data = d; e.to = to; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    do @(negedge fxclk); while (cyc < n);
  endtask

  // Raise one request, return the cycle of its accepting edge; drop valid afterwards.
  task automatic do_req(input logic s, input logic [23:0] d, output int acc);
    acc = -1;
    @(posedge fxclk); #1;
    if (s) begin req1_valid = 1'b1; req1_data = d; end
    else   begin req0_valid = 1'b1; req0_data = d; end
    for (int i = 0; i < 40; i++) begin
      @(negedge fxclk);
      if ((s ? req1_ready : req0_ready) === 1'b1) begin
        chk("other_ready_low", 32'(s ? req0_ready : req1_ready), 0);
        acc = cyc + 1;
        break;
      end
    end
    chk("req_accepted", 32'(acc >= 0), 1);
    @(posedge fxclk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_start(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge fxclk);
      if (spi_tx_start === 1'b1) begin t = cyc; break; end
    end
    chk("tx_start_seen", 32'(t >= 0), 1);
  endtask

  // tx_end is high during cycle t+d (d>=2), i.e. sampled on edge t+d+1; response lands at t+d+1.
  task automatic pulse_end(input int t, input int d, input logic [23:0] rx);
    wait_neg(t + d - 1);
    @(posedge fxclk); #1;
    spi_tx_end = 1'b1; spi_rx_data = rx;
    @(posedge fxclk); #1;
    spi_tx_end = 1'b0; spi_rx_data = 24'h0;
  endtask

  function automatic logic exp_src(input int k);
`ifdef SPI_SCHED_FIXED_PRIO_EN
    return 1'b0;
`else
    return k[0];
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t, prev_t;
    logic es;
    logic [23:0] rx;
    reset_in = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
    spi_tx_end = 0; spi_rx_data = 0;
    repeat (3) @(posedge fxclk);
    #1 reset_in = 1'b0;
    @(negedge fxclk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_start", 32'(spi_tx_start), 0);
    chk("rst_tx_data", 32'(spi_tx_data), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_src", 32'(rsp_src), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 0);

    // Single host request, tx_end 50 cycles after the start pulse.
    do_req(1'b0, 24'h000D00, acc);
    wait_start(t);
    chk("host_start_lat", t, acc);
    chk("host_tx_data", 32'(spi_tx_data), 32'h000D00);
    chk("host_busy", 32'(busy), 1);
    wait_neg(t + 1);
    chk("host_start_1cyc", 32'(spi_tx_start), 0);
    push(1'b0, 24'h00A5C3, 1'b0, t + 51);
    pulse_end(t, 50, 24'h00A5C3);
    wait_neg(t + 50 + G);
    chk("host_gap_busy", 32'(busy), 1);
    wait_neg(t + 51 + G);
    chk("host_idle", 32'(busy), 0);

    // Timeout on requester 1: WAIT_END entered at t+1, response T cycles later.
    do_req(1'b1, 24'h0ABCDE, acc);
    wait_start(t);
    chk("to_tx_data", 32'(spi_tx_data), 32'h0ABCDE);
    push(1'b1, 24'h0, 1'b1, t + 1 + T);
    wait_neg(t + T + G);
    chk("to_gap_busy", 32'(busy), 1);
    wait_neg(t + T + G + 1);
    chk("to_idle", 32'(busy), 0);

    // Contention: both valid throughout four transfers, tx_end 5 cycles after each start.
    @(posedge fxclk); #1;
    req0_valid = 1; req0_data = 24'h111111;
    req1_valid = 1; req1_data = 24'h222222;
    prev_t = 0;
    for (int k = 0; k < 4; k++) begin
      wait_start(t);
      es = exp_src(k);
      chk("cont_tx_data", 32'(spi_tx_data), es ? 32'h222222 : 32'h111111);
      if (k > 0) chk("cont_spacing", t - prev_t, 5 + G + 2);
      prev_t = t;
      rx = 24'hC00000 | 24'(k);
      push(es, rx, 1'b0, t + 6);
      pulse_end(t, 5, rx);
      if (k == 3) begin req0_valid = 0; req1_valid = 0; end
    end
    wait_neg(prev_t + 6 + G + 2);
    chk("cont_idle", 32'(busy), 0);

    // tx_end on the very cycle the timeout would fire: normal response.
    do_req(1'b0, 24'h5A5A5A, acc);
    wait_start(t);
    push(1'b0, 24'h3C3C3C, 1'b0, t + T + 1);
    pulse_end(t, T, 24'h3C3C3C);
    wait_neg(t + T + 1 + G);
    chk("sim_idle", 32'(busy), 0);

    // Reset mid-WAIT_END, followed by a stray tx_end.
    do_req(1'b1, 24'h777777, acc);
    wait_start(t);
    wait_neg(t + 10);
    @(posedge fxclk); #1 reset_in = 1'b1;
    @(posedge fxclk); #1 reset_in = 1'b0;
    spi_tx_end = 1'b1; spi_rx_data = 24'hFFFFFF;
    @(posedge fxclk); #1 spi_tx_end = 1'b0; spi_rx_data = 24'h0;
    @(negedge fxclk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tx_data", 32'(spi_tx_data), 0);
    chk("mid_rst_rsp", 32'({rsp_valid, rsp_src, rsp_timeout}), 0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 0);
    wait_neg(cyc + 10);
    chk("mid_rst_still_idle", 32'(busy), 0);
    do_req(1'b0, 24'h0F0F0F, acc);
    wait_start(t);
    chk("post_rst_start_lat", t, acc);
    chk("post_rst_tx_data", 32'(spi_tx_data), 32'h0F0F0F);
    push(1'b0, 24'h123456, 1'b0, t + 4);
    pulse_end(t, 3, 24'h123456);
    wait_neg(t + 4 + G + 2);

    chk("rsp_queue_drained", q.size(), 0);
    chk("ready_never_both", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
